// File: rtl/dmem_arb_pkg.sv
// Shared types and constants for the data-memory port arbiter.
`timescale 1ns/1ps
package dmem_arb_pkg;

    typedef enum logic [0:0] {
        ARB_FREE      = 1'b0,
        ARB_HOST_LOCK = 1'b1
    } arb_state_e;

    localparam logic PORT_CORE = 1'b0;
    localparam logic PORT_HOST = 1'b1;

    localparam int unsigned DEF_MAX_WAIT = 32'd4;

endpackage

// File: rtl/dmem_arb_waitcnt.sv
// Saturating host wait counter with clear; flags when the host has waited MAX_WAIT cycles.
`timescale 1ns/1ps
module dmem_arb_waitcnt
    import dmem_arb_pkg::*;
#(
    parameter int unsigned MAX_WAIT = DEF_MAX_WAIT
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic inc_i,
    input  logic clr_i,
    output logic sat_o
);

    localparam int unsigned CW = (MAX_WAIT < 32'd1) ? 32'd1 : $clog2(MAX_WAIT + 32'd1);

    logic [CW-1:0] cnt_r;

    // Wait counter: clear wins over increment, saturates at MAX_WAIT
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            cnt_r <= '0;
        end else if (clr_i) begin
            cnt_r <= '0;
        end else if (inc_i && (cnt_r != CW'(MAX_WAIT))) begin
            cnt_r <= cnt_r + CW'(1);
        end else begin
            cnt_r <= cnt_r;
        end
    end

    assign sat_o = (cnt_r == CW'(MAX_WAIT));

endmodule

// File: rtl/dmem_arbiter.sv
// Core/host arbiter for the shared dcache port; core has priority, host may lock the port.
// Optional host starvation guard compiled in with DMEM_ARB_STARVE_GUARD_EN.
`timescale 1ns/1ps
module dmem_arbiter
    import dmem_arb_pkg::*;
#(
    parameter int unsigned AW       = 32'd6,
    parameter int unsigned DW       = 32'd32,
    parameter int unsigned MAX_WAIT = DEF_MAX_WAIT
) (
    input  logic          clk_i,
    input  logic          rst_i,

    input  logic          core_req_i,
    input  logic          core_we_i,
    input  logic [AW-1:0] core_addr_i,
    input  logic [DW-1:0] core_dato_i,
    output logic          core_gnt_o,
    output logic          core_valid_o,
    output logic [DW-1:0] core_dato_o,

    input  logic          host_req_i,
    input  logic          host_we_i,
    input  logic [AW-1:0] host_addr_i,
    input  logic [DW-1:0] host_dato_i,
    input  logic          host_lock_i,
    output logic          host_gnt_o,
    output logic          host_valid_o,
    output logic [DW-1:0] host_dato_o,

    output logic [AW-1:0] mem_addr_o,
    output logic [DW-1:0] mem_dato_o,
    output logic          mem_memwrite_o,
    output logic          mem_memread_o,
    input  logic [DW-1:0] mem_dato_i
);

    arb_state_e    state_r;
    arb_state_e    state_nxt_s;
    logic          core_gnt_s;
    logic          host_gnt_s;
    logic          host_force_s;
    logic          sel_s;
    logic          core_rd_r;
    logic          host_rd_r;
    logic [DW-1:0] core_hold_r;
    logic [DW-1:0] host_hold_r;

`ifdef DMEM_ARB_STARVE_GUARD_EN
    logic wait_inc_s;
    logic wait_clr_s;
    logic wait_sat_s;

    assign wait_inc_s   = (state_r == ARB_FREE) && host_req_i && !host_gnt_s;
    assign wait_clr_s   = host_gnt_s || !host_req_i;
    assign host_force_s = wait_sat_s;

    dmem_arb_waitcnt #(
        .MAX_WAIT (MAX_WAIT)
    ) u_waitcnt (
        .clk_i (clk_i),
        .rst_i (rst_i),
        .inc_i (wait_inc_s),
        .clr_i (wait_clr_s),
        .sat_o (wait_sat_s)
    );
`else
    assign host_force_s = 1'b0;
`endif

    // Arbitration state register
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_r <= ARB_FREE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Grant decision and next state; no grant is issued while reset is held
    always_comb begin
        core_gnt_s  = 1'b0;
        host_gnt_s  = 1'b0;
        state_nxt_s = state_r;
        if (rst_i) begin
            state_nxt_s = ARB_FREE;
        end else begin
            case (state_r)
                ARB_FREE: begin
                    if (host_req_i && host_force_s) begin
                        host_gnt_s = 1'b1;
                    end else if (core_req_i) begin
                        core_gnt_s = 1'b1;
                    end else if (host_req_i) begin
                        host_gnt_s = 1'b1;
                    end else begin
                        host_gnt_s = 1'b0;
                    end
                    if (host_gnt_s && host_lock_i) begin
                        state_nxt_s = ARB_HOST_LOCK;
                    end else begin
                        state_nxt_s = ARB_FREE;
                    end
                end
                ARB_HOST_LOCK: begin
                    // Exit cycle still withholds the core grant
                    host_gnt_s = host_req_i;
                    if (!host_req_i && !host_lock_i) begin
                        state_nxt_s = ARB_FREE;
                    end else begin
                        state_nxt_s = ARB_HOST_LOCK;
                    end
                end
                default: begin
                    state_nxt_s = ARB_FREE;
                end
            endcase
        end
    end

    assign sel_s = host_gnt_s ? PORT_HOST : PORT_CORE;

    // Winner's fields onto the dcache port; idle port drives zeros
    always_comb begin
        mem_addr_o     = '0;
        mem_dato_o     = '0;
        mem_memwrite_o = 1'b0;
        mem_memread_o  = 1'b0;
        if (core_gnt_s || host_gnt_s) begin
            case (sel_s)
                PORT_CORE: begin
                    mem_addr_o     = core_addr_i;
                    mem_dato_o     = core_dato_i;
                    mem_memwrite_o = core_we_i;
                    mem_memread_o  = !core_we_i;
                end
                PORT_HOST: begin
                    mem_addr_o     = host_addr_i;
                    mem_dato_o     = host_dato_i;
                    mem_memwrite_o = host_we_i;
                    mem_memread_o  = !host_we_i;
                end
                default: begin
                    mem_addr_o = '0;
                end
            endcase
        end else begin
            mem_addr_o = '0;
        end
    end

    // Read-return pipeline bits and last-value hold registers
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            core_rd_r   <= 1'b0;
            host_rd_r   <= 1'b0;
            core_hold_r <= '0;
            host_hold_r <= '0;
        end else begin
            core_rd_r <= core_gnt_s && !core_we_i;
            host_rd_r <= host_gnt_s && !host_we_i;
            if (core_rd_r) begin
                core_hold_r <= mem_dato_i;
            end else begin
                core_hold_r <= core_hold_r;
            end
            if (host_rd_r) begin
                host_hold_r <= mem_dato_i;
            end else begin
                host_hold_r <= host_hold_r;
            end
        end
    end

    assign core_gnt_o   = core_gnt_s;
    assign host_gnt_o   = host_gnt_s;
    assign core_valid_o = core_rd_r;
    assign host_valid_o = host_rd_r;
    assign core_dato_o  = core_rd_r ? mem_dato_i : core_hold_r;
    assign host_dato_o  = host_rd_r ? mem_dato_i : host_hold_r;

endmodule

// File: doc/dmem_arbiter.md
# dmem_arbiter

Arbiter sharing the single data-memory (dcache) port of the single-cycle core between the core's load/store path and a host requester (program/data loader, debug access). Sits between the core's memory-access stage and the `dcache` instance. Drives a core stall via withheld grants, since a denied core request freezes the PC. Read data returns one cycle after grant, matching a registered-read dcache.

## Interface
- `AW`, 6: word-address width (dcache depth 2^AW words).
- `DW`, 32: data width.
- `MAX_WAIT`, 4: cycles a waiting host tolerates before a forced grant (used only with the macro).

- `clk_i`  in  1  clock, rising edge.
- `rst_i`  in  1  reset, asynchronous, active-high.
- `core_req_i`  in  1  core access request.
- `core_we_i`  in  1  1 = write, 0 = read.
- `core_addr_i`  in  AW  word address.
- `core_dato_i`  in  DW  write data.
- `core_gnt_o`  out  1  core access accepted this cycle.
- `core_valid_o`  out  1  core read data valid.
- `core_dato_o`  out  DW  core read data.
- `host_req_i`, `host_we_i`, `host_addr_i`, `host_dato_i`, `host_gnt_o`, `host_valid_o`, `host_dato_o`: same as the core set, for the host.
- `host_lock_i`  in  1  host requests exclusive ownership (burst).
- `mem_addr_o`  out  AW  dcache address.
- `mem_dato_o`  out  DW  dcache write data.
- `mem_memwrite_o`  out  1  dcache write enable.
- `mem_memread_o`  out  1  dcache read enable.
- `mem_dato_i`  in  DW  dcache read data, valid one cycle after `mem_memread_o`.

## Operation
- Each granted access occupies exactly one cycle. The port is fully pipelined, so a new grant is possible every cycle.
- Requesters hold `req`/`we`/`addr`/`dato` stable until they see `gnt` high in the same cycle.
- Grant is combinational from the requests and the registered state. The winner's fields are muxed onto `mem_*`.
  - `mem_memwrite_o = gnt & we`
  - `mem_memread_o = gnt & ~we`
  - With no grant, all `mem_*` outputs are 0.
- Default policy: fixed priority, core over host.
- State machine (one state register):
  - **FREE**: arbitrate per cycle. If the host is granted with `host_lock_i`=1, next state is HOST_LOCK.
  - **HOST_LOCK**: only the host can be granted; `core_gnt_o`=0 regardless of `core_req_i`. Leave to FREE on the first cycle with `host_req_i`=0 and `host_lock_i`=0. The exit cycle itself still grants no core access; the core wins again from the next cycle.
- Read return: a per-port valid pipeline bit is set for the cycle after a read grant. That cycle, `<port>_valid_o`=1 and `<port>_dato_o`=`mem_dato_i`.
- `<port>_dato_o` holds its last value when not valid.
- Write grants never raise valid.
- The same address from both ports in one cycle is no hazard: only one is granted. Ordering equals grant order.

## Timing
- Reset state:
  - state FREE.
  - all `gnt`/`valid` = 0; `dato_o` = 0; `mem_*` = 0.
  - wait counter = 0.
- Grant latency: 0 cycles (same cycle as request when won). Read latency: 1 cycle after grant.
- Back-to-back host reads at cycles t and t+1 produce valid at t+1 and t+2.
- Reset asserted mid-lock or with a read in flight: state returns to FREE and the in-flight valid is dropped (no valid after reset release).
- The core sees a stall of one cycle per host grant outside a lock, and for the whole duration of HOST_LOCK.

## Configuration
- `DMEM_ARB_STARVE_GUARD_EN`: compiles in the host starvation guard.
  - A wait counter (0..MAX_WAIT) increments each cycle in FREE with `host_req_i`=1 and no host grant.
  - It clears on a host grant, or when `host_req_i`=0.
  - When the counter equals MAX_WAIT, the host wins over the core that cycle.
- Without the macro: pure core priority. The host may starve indefinitely while the core requests every cycle.

## Structure
- Package `dmem_arb_pkg` holds:
  - the state typedef (`ARB_FREE`, `ARB_HOST_LOCK`);
  - port-id constants (`PORT_CORE`=0, `PORT_HOST`=1);
  - the default `MAX_WAIT`.
- Sub-module `dmem_arb_waitcnt` (saturating wait counter with clear), instantiated only under the macro. The grant mux stays inline.

## Test plan
- Core read 0x05 alone, dcache word 5 = 0x1234_5678 → `core_gnt_o`=1 at t, `mem_memread_o`=1 and `mem_addr_o`=0x05 at t, `core_valid_o`=1 with 0x1234_5678 at t+1.
- Core and host both request at t (host write 0xAA to 0x02) → core granted at t, host granted at t+1, `mem_memwrite_o`=1 with `mem_addr_o`=0x02 at t+1.
- Host lock burst: writes to 0x00..0x03 with `host_lock_i`=1 while the core requests continuously → four consecutive host grants, `core_gnt_o`=0 throughout, core granted on the cycle after lock release.
- With `DMEM_ARB_STARVE_GUARD_EN` and `MAX_WAIT`=4, core requesting every cycle and host requesting from t → host granted at t+4, core at all other cycles. Without the macro, the host is never granted.
- `rst_i` pulsed during HOST_LOCK with a host read in flight → all outputs 0, no `host_valid_o` after release, core granted on its first request.
- Idle cycles (no requests) → all `mem_*`=0, both `gnt`=0, `dato_o` hold their previous values.
